// File: rtl/dual_ram_arbiter.sv
// Two-client arbiter sharing one dual-address RAM.
// Port 0 reads and writes; port 1 only reads.
// Every transaction runs IDLE -> EXEC -> RESP. Requests are sampled only in IDLE.
module dual_ram_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              ram_wr_en,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_addr_0,
  output logic              ram_port_en_0,
  output logic [ADDR_W-1:0] ram_addr_1,
  output logic              ram_port_en_1,
  input  logic [DATA_W-1:0] ram_data_out_0,
  input  logic [DATA_W-1:0] ram_data_out_1
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic              en0_q, en0_d, en1_q, en1_d;
  // Per-client record of the latched transaction: served, is a read, read sits on port 1.
  logic              c0_srv_q, c0_srv_d, c1_srv_q, c1_srv_d;
  logic              c0_rd_q, c0_rd_d, c1_rd_q, c1_rd_d;
  logic              c0_p1_q, c0_p1_d, c1_p1_q, c1_p1_d;
  logic              c0_ack_q, c0_ack_d, c1_ack_q, c1_ack_d;
  logic [DATA_W-1:0] c0_rdata_q, c0_rdata_d, c1_rdata_q, c1_rdata_d;

  logic use_c0, use_c1, c0_on_p1, c1_on_p1;

  // Pair the current requests. Only a write-write conflict serializes; the writer owns port 0.
  always_comb begin
    use_c0   = 1'b0;
    use_c1   = 1'b0;
    c0_on_p1 = 1'b0;
    c1_on_p1 = 1'b0;
    if (c0_req && c1_req) begin
      if (c0_we && c1_we) begin
        use_c0 = !rr_q;
        use_c1 = rr_q;
      end else begin
        use_c0   = 1'b1;
        use_c1   = 1'b1;
        c0_on_p1 = c1_we;
        c1_on_p1 = !c1_we;
      end
    end else begin
      use_c0 = c0_req;
      use_c1 = c1_req;
    end
  end

  // Next-state logic. RAM-side registers default to 0, so they are live only during EXEC.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    wr_en_d    = 1'b0;
    data_in_d  = '0;
    addr0_d    = '0;
    en0_d      = 1'b0;
    addr1_d    = '0;
    en1_d      = 1'b0;
    c0_srv_d   = c0_srv_q;
    c1_srv_d   = c1_srv_q;
    c0_rd_d    = c0_rd_q;
    c1_rd_d    = c1_rd_q;
    c0_p1_d    = c0_p1_q;
    c1_p1_d    = c1_p1_q;
    c0_ack_d   = 1'b0;
    c1_ack_d   = 1'b0;
    c0_rdata_d = c0_rdata_q;
    c1_rdata_d = c1_rdata_q;
    case (state_q)
      StIdle: begin
        if (c0_req || c1_req) begin
          state_d = StExec;
          if (c0_req && c1_req && c0_we && c1_we) rr_d = !rr_q;
          c0_srv_d = use_c0;
          c1_srv_d = use_c1;
          c0_rd_d  = use_c0 && !c0_we;
          c1_rd_d  = use_c1 && !c1_we;
          c0_p1_d  = c0_on_p1;
          c1_p1_d  = c1_on_p1;
          if (use_c0) begin
            if (c0_on_p1) begin
              en1_d   = 1'b1;
              addr1_d = c0_addr;
            end else begin
              en0_d     = 1'b1;
              addr0_d   = c0_addr;
              wr_en_d   = c0_we;
              data_in_d = c0_we ? c0_wdata : '0;
            end
          end
          if (use_c1) begin
            if (c1_on_p1) begin
              en1_d   = 1'b1;
              addr1_d = c1_addr;
            end else begin
              en0_d     = 1'b1;
              addr0_d   = c1_addr;
              wr_en_d   = c1_we;
              data_in_d = c1_we ? c1_wdata : '0;
            end
          end
        end
      end
      StExec: begin
        state_d  = StResp;
        c0_ack_d = c0_srv_q;
        c1_ack_d = c1_srv_q;
        // Read data is taken only from a port this transaction enabled.
        if (c0_srv_q && c0_rd_q) c0_rdata_d = c0_p1_q ? ram_data_out_1 : ram_data_out_0;
        if (c1_srv_q && c1_rd_q) c1_rdata_d = c1_p1_q ? ram_data_out_1 : ram_data_out_0;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; asynchronous reset kills any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_q       <= 1'b0;
      wr_en_q    <= 1'b0;
      data_in_q  <= '0;
      addr0_q    <= '0;
      en0_q      <= 1'b0;
      addr1_q    <= '0;
      en1_q      <= 1'b0;
      c0_srv_q   <= 1'b0;
      c1_srv_q   <= 1'b0;
      c0_rd_q    <= 1'b0;
      c1_rd_q    <= 1'b0;
      c0_p1_q    <= 1'b0;
      c1_p1_q    <= 1'b0;
      c0_ack_q   <= 1'b0;
      c1_ack_q   <= 1'b0;
      c0_rdata_q <= '0;
      c1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      wr_en_q    <= wr_en_d;
      data_in_q  <= data_in_d;
      addr0_q    <= addr0_d;
      en0_q      <= en0_d;
      addr1_q    <= addr1_d;
      en1_q      <= en1_d;
      c0_srv_q   <= c0_srv_d;
      c1_srv_q   <= c1_srv_d;
      c0_rd_q    <= c0_rd_d;
      c1_rd_q    <= c1_rd_d;
      c0_p1_q    <= c0_p1_d;
      c1_p1_q    <= c1_p1_d;
      c0_ack_q   <= c0_ack_d;
      c1_ack_q   <= c1_ack_d;
      c0_rdata_q <= c0_rdata_d;
      c1_rdata_q <= c1_rdata_d;
    end
  end

  assign ram_wr_en     = wr_en_q;
  assign ram_data_in   = data_in_q;
  assign ram_addr_0    = addr0_q;
  assign ram_port_en_0 = en0_q;
  assign ram_addr_1    = addr1_q;
  assign ram_port_en_1 = en1_q;
  assign c0_ack        = c0_ack_q;
  assign c1_ack        = c1_ack_q;
  assign c0_rdata      = c0_rdata_q;
  assign c1_rdata      = c1_rdata_q;

endmodule

// File: tb/tb_dual_ram_arbiter.sv
// Directed bench for dual_ram_arbiter with a behavioural 16x8 dual-address RAM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dual_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       c0_req, c0_we, c1_req, c1_we;
  logic [3:0] c0_addr, c1_addr;
  logic [7:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
  logic       c0_ack, c1_ack;
  logic       ram_wr_en, ram_port_en_0, ram_port_en_1;
  logic [7:0] ram_data_in;
  logic [3:0] ram_addr_0, ram_addr_1;
  wire  [7:0] ram_data_out_0, ram_data_out_1;
  logic [7:0] mem [16];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] bb_addr [4];
  logic [7:0] bb_data [4];

  always #5 clk = ~clk;

  dual_ram_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .c0_req         (c0_req),
    .c0_we          (c0_we),
    .c0_addr        (c0_addr),
    .c0_wdata       (c0_wdata),
    .c0_ack         (c0_ack),
    .c0_rdata       (c0_rdata),
    .c1_req         (c1_req),
    .c1_we          (c1_we),
    .c1_addr        (c1_addr),
    .c1_wdata       (c1_wdata),
    .c1_ack         (c1_ack),
    .c1_rdata       (c1_rdata),
    .ram_wr_en      (ram_wr_en),
    .ram_data_in    (ram_data_in),
    .ram_addr_0     (ram_addr_0),
    .ram_port_en_0  (ram_port_en_0),
    .ram_addr_1     (ram_addr_1),
    .ram_port_en_1  (ram_port_en_1),
    .ram_data_out_0 (ram_data_out_0),
    .ram_data_out_1 (ram_data_out_1)
  );

  // Behavioural RAM: asynchronous read, write on the rising edge, Z while a port is disabled.
  assign ram_data_out_0 = ram_port_en_0 ? mem[ram_addr_0] : 8'hzz;
  assign ram_data_out_1 = ram_port_en_1 ? mem[ram_addr_1] : 8'hzz;
  always @(posedge clk) if (ram_wr_en) mem[ram_addr_0] <= ram_data_in;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete single-client transaction, starting and ending in IDLE.
  task automatic single(input bit cl, input bit we, input logic [3:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input string tag);
    if (!cl) begin
      c0_req = 1'b1; c0_we = we; c0_addr = a; c0_wdata = d;
    end else begin
      c1_req = 1'b1; c1_we = we; c1_addr = a; c1_wdata = d;
    end
    tick();
    chk({tag, "_p1_idle"}, ram_port_en_1, 0);
    tick();
    chk({tag, "_ack"}, cl ? c1_ack : c0_ack, 1);
    chk({tag, "_other_ack"}, cl ? c0_ack : c1_ack, 0);
    if (!we) chk({tag, "_rdata"}, cl ? c1_rdata : c0_rdata, exp_rd);
    c0_req = 1'b0;
    c1_req = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;

    // Reset state
    tick();
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_en0", ram_port_en_0, 0);
    chk("rst_en1", ram_port_en_1, 0);
    chk("rst_addr0", ram_addr_0, 0);
    chk("rst_data_in", ram_data_in, 0);
    chk("rst_acks", {c0_ack, c1_ack}, 0);
    chk("rst_rdata", {c0_rdata, c1_rdata}, 0);
    rst_n = 1'b1;
    tick();

    // Single write then read on port 0
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = 4'd7; c0_wdata = 8'hA5;
    tick();
    chk("sw_exec_ctl", {ram_wr_en, ram_port_en_0, ram_port_en_1}, 3'b110);
    chk("sw_exec_addr", ram_addr_0, 7);
    chk("sw_exec_data", ram_data_in, 8'hA5);
    chk("sw_exec_noack", c0_ack, 0);
    tick();
    chk("sw_ack", c0_ack, 1);
    chk("sw_resp_en", {ram_wr_en, ram_port_en_0, ram_port_en_1}, 0);
    chk("sw_rdata_hold", c0_rdata, 0);
    c0_req = 1'b0;
    tick();
    chk("sw_ack_pulse", c0_ack, 0);
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = 4'd7; c0_wdata = 8'h00;
    tick();
    chk("sr_exec_ctl", {ram_wr_en, ram_port_en_0, ram_port_en_1}, 3'b010);
    chk("sr_exec_data0", ram_data_in, 0);
    tick();
    chk("sr_ack", c0_ack, 1);
    chk("sr_rdata", c0_rdata, 8'hA5);
    c0_req = 1'b0;
    tick();

    // Dual read in one transaction
    single(0, 1, 4'd2, 8'h11, 8'h00, "pre2");
    single(1, 1, 4'd9, 8'h22, 8'h00, "pre9");
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = 4'd2;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 4'd9;
    tick();
    chk("dr_en", {ram_wr_en, ram_port_en_0, ram_port_en_1}, 3'b011);
    chk("dr_addrs", {ram_addr_0, ram_addr_1}, 8'h29);
    tick();
    chk("dr_acks", {c0_ack, c1_ack}, 2'b11);
    chk("dr_rdata", {c0_rdata, c1_rdata}, 16'h1122);
    c0_req = 1'b0; c1_req = 1'b0;
    tick();

    // Write and read to the same address: reader sees the old word
    single(0, 1, 4'd4, 8'h33, 8'h00, "pre4");
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = 4'd4;
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 4'd4; c1_wdata = 8'h44;
    tick();
    chk("wr_en", {ram_wr_en, ram_port_en_0, ram_port_en_1}, 3'b111);
    chk("wr_port_map", {ram_addr_0, ram_addr_1, ram_data_in}, 16'h4444);
    tick();
    chk("wr_acks", {c0_ack, c1_ack}, 2'b11);
    chk("wr_old_data", c0_rdata, 8'h33);
    chk("wr_c1_hold", c1_rdata, 8'h22);
    c0_req = 1'b0; c1_req = 1'b0;
    tick();
    single(0, 0, 4'd4, 8'h00, 8'h44, "wr_after");

    // Write-write conflict, round-robin starting at c0
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = 4'd0; c0_wdata = 8'h01;
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 4'd0; c1_wdata = 8'h02;
    tick();
    chk("ww1_first_data", ram_data_in, 8'h01);
    chk("ww1_p1_off", ram_port_en_1, 0);
    tick();
    chk("ww1_first_ack", {c0_ack, c1_ack}, 2'b10);
    c0_req = 1'b0;
    tick();
    tick();
    chk("ww1_second_data", ram_data_in, 8'h02);
    tick();
    chk("ww1_second_ack", {c0_ack, c1_ack}, 2'b01);
    c1_req = 1'b0;
    tick();
    single(0, 0, 4'd0, 8'h00, 8'h02, "ww1_mem");

    // Repeat the conflict: c1 now wins
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = 4'd0; c0_wdata = 8'h03;
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 4'd0; c1_wdata = 8'h04;
    tick();
    chk("ww2_first_data", ram_data_in, 8'h04);
    tick();
    chk("ww2_first_ack", {c0_ack, c1_ack}, 2'b01);
    c1_req = 1'b0;
    tick();
    tick();
    tick();
    chk("ww2_second_ack", {c0_ack, c1_ack}, 2'b10);
    c0_req = 1'b0;
    tick();
    single(1, 0, 4'd0, 8'h00, 8'h03, "ww2_mem");

    // Back-to-back stream of four reads from c0
    bb_addr[0] = 4'd7; bb_addr[1] = 4'd2; bb_addr[2] = 4'd9; bb_addr[3] = 4'd4;
    bb_data[0] = 8'hA5; bb_data[1] = 8'h11; bb_data[2] = 8'h22; bb_data[3] = 8'h44;
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = bb_addr[0];
    tick();
    chk("bb0_exec_noack", c0_ack, 0);
    tick();
    chk("bb0_ack", c0_ack, 1);
    chk("bb0_rdata", c0_rdata, bb_data[0]);
    for (int i = 1; i < 4; i++) begin
      c0_addr = bb_addr[i];
      tick();
      chk($sformatf("bb%0d_idle_noack", i), c0_ack, 0);
      tick();
      chk($sformatf("bb%0d_exec_noack", i), c0_ack, 0);
      tick();
      chk($sformatf("bb%0d_ack", i), c0_ack, 1);
      chk($sformatf("bb%0d_rdata", i), c0_rdata, bb_data[i]);
    end
    c0_req = 1'b0;
    tick();
    chk("bb_done_noack", c0_ack, 0);

    // Reset in the middle of an EXEC write
    single(0, 1, 4'd3, 8'h77, 8'h00, "pre3");
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = 4'd3; c0_wdata = 8'h5A;
    tick();
    chk("mr_exec_wr_en", ram_wr_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_async_ctl", {ram_wr_en, ram_port_en_0}, 0);
    c0_req = 1'b0;
    tick();
    chk("mr_no_ack", c0_ack, 0);
    chk("mr_rdata_clr", c0_rdata, 0);
    rst_n = 1'b1;
    tick();
    chk("mr_still_no_ack", c0_ack, 0);
    single(0, 0, 4'd3, 8'h00, 8'h77, "mr_readback");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_ram_arbiter.md
Name: dual_ram_arbiter

Overview:
- Shares one 16x8 dual-address RAM between two client requesters, c0 and c1.
- RAM port 0 is the only port that can write and also reads; RAM port 1 is read-only.
- Each client issues a read or a write using a req/ack handshake. The arbiter latches the requests, drives the RAM ports from registers and returns registered read data.
- Write-write conflicts are resolved round-robin; every other pair of requests is served in the same transaction.

Parameters:
- DATA_W, 8, RAM word width
- ADDR_W, 4, RAM address width (16 entries)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- c0_req  in  1  client 0 request; held high until c0_ack is seen
- c0_we  in  1  client 0: 1 = write, 0 = read
- c0_addr  in  ADDR_W  client 0 address
- c0_wdata  in  DATA_W  client 0 write data
- c0_ack  out  1  one-cycle completion pulse
- c0_rdata  out  DATA_W  read data, valid while c0_ack=1
- c1_req, c1_we, c1_addr, c1_wdata, c1_ack, c1_rdata: same as the c0 ports, for client 1
- ram_wr_en  out  1  RAM write enable
- ram_data_in  out  DATA_W  RAM write data
- ram_addr_0  out  ADDR_W  RAM port 0 address
- ram_port_en_0  out  1  RAM port 0 enable
- ram_addr_1  out  ADDR_W  RAM port 1 address
- ram_port_en_1  out  1  RAM port 1 enable
- ram_data_out_0  in  DATA_W  RAM port 0 read data (Z when disabled)
- ram_data_out_1  in  DATA_W  RAM port 1 read data (Z when disabled)

Behaviour:
- Reset clears asynchronously:
  - state = IDLE, rr_ptr = 0
  - all RAM-side outputs = 0
  - c0_ack = c1_ack = 0, c0_rdata = c1_rdata = 0
- Reset is released synchronously to clk.
- FSM states and transitions:
  - IDLE: stays in IDLE while no req is high. When any req is high, the arbiter latches the command set and moves to EXEC.
  - EXEC: RAM outputs are driven from the command registers for exactly one cycle. On the closing edge the RAM writes, and the arbiter captures ram_data_out_0/1 into each served reader's c*_rdata. Moves to RESP.
  - RESP: c*_ack=1 for each served client, all RAM enables = 0. Moves to IDLE.
- Latency: req high in IDLE cycle T gives ack in cycle T+2. Maximum rate is one transaction per 3 cycles.
- Command pairing, decided in IDLE:
  - Single request (read or write): served on port 0.
  - Both reads: c0 on port 0, c1 on port 1, same transaction.
  - One write and one read: the writer goes on port 0, the reader on port 1, same transaction. The reader receives pre-write data, including when the addresses are equal.
  - Both writes: client rr_ptr is served on port 0, then rr_ptr flips to the other client. The loser stays pending and is served in the next IDLE->EXEC pass. rr_ptr changes only on write-write conflict.
- Port enables:
  - ram_wr_en=1 only in EXEC with a write command on port 0.
  - ram_port_en_0 and ram_port_en_1 are high only in EXEC, and only for a port that carries a command.
  - An unused port keeps its enable at 0 and its address/data at 0.
- The arbiter never samples ram_data_out_x while that port's enable is 0.
- c*_rdata updates only on read completion and holds its value across write acks.
- Requests are not sampled in EXEC or RESP.
- Client rules:
  - A client must deassert req (or present a new command) on the edge after seeing ack.
  - Dropping req before ack is illegal. A command already latched completes regardless.
- Reset asserted mid-EXEC forces ram_wr_en low immediately; that write is lost and no ack is issued.

Test Plan:
- Reset: rst_n=0 in mid-EXEC of a c0 write of 0x5A to addr 3 -> ram_wr_en drops asynchronously, no ack, and a later read of addr 3 returns the prior contents.
- Single ops: c0 writes 0xA5 to addr 7 (ack at T+2), then c0 reads addr 7 -> c0_rdata=0xA5 with c0_ack at T+2, port 1 enable never asserted.
- Dual read: mem[2]=0x11, mem[9]=0x22; c0 reads 2 and c1 reads 9 in the same cycle -> both acks in the same cycle, c0_rdata=0x11, c1_rdata=0x22.
- Write+read same address: mem[4]=0x33; c1 writes 0x44 to addr 4 while c0 reads addr 4 -> single transaction with c1 on port 0 and c0 on port 1; c0_rdata=0x33, then mem[4]=0x44.
- Write-write round-robin: after reset, both clients write to addr 0 (c0: 0x01, c1: 0x02) -> c0 acked first, c1 three cycles later, final mem[0]=0x02. Repeat the conflict -> c1 is served first.
- Back-to-back: c0 holds a stream of 4 reads, changing its command after each ack -> one ack every 3 cycles, no duplicate or skipped acks.
